high_score_ram_controller: RTL and testbench

Writer side of the per-user high-score store. After reset it loads the six stored high scores from the single-port score RAM into shadow registers. It drives those registers onto scoreUserAddr0..scoreUserAddr5 for the hex4/hex5 round-robin display. At each game end it compares the finished game score with the player's stored score and writes the RAM only on a new high score; it also supports a clear-all-scores command.

---
 rtl/high_score_ram_controller_pkg.sv | 31 +++
 rtl/high_score_ram_controller_if.sv | 26 ++
 rtl/high_score_ram_controller.sv | 180 ++++++++++++++++++
 tb/tb_high_score_ram_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/high_score_ram_controller_pkg.sv
// Shared types and constants for the high-score RAM controller.
package high_score_ram_controller_pkg;

    localparam int unsigned DEF_NUM_USERS = 6;
    localparam int unsigned SCORE_W       = 8;
    localparam int unsigned USER_W        = 3;
    localparam int unsigned CNT_W         = 2;
    localparam int unsigned SLOTS         = 1 << USER_W;

    localparam logic [SCORE_W-1:0] BLANK_SCORE = 8'h00;

    typedef enum logic [1:0] {
        S_LOAD_REQ  = 2'd0,
        S_LOAD_WAIT = 2'd1,
        S_IDLE      = 2'd2,
        S_CLEAR     = 2'd3
    } state_t;

    // One game-end report: which player, what final score.
    typedef struct packed {
        logic [USER_W-1:0]  user;
        logic [SCORE_W-1:0] score;
    } game_req_t;

    // Unsigned compare; ordering of 2-digit BCD matches plain binary ordering.
    function automatic logic score_gt(input logic [SCORE_W-1:0] a,
                                      input logic [SCORE_W-1:0] b);
        return a > b;
    endfunction

endpackage

// File: rtl/high_score_ram_controller_if.sv
// Game-side command inputs plus the single-port score RAM bus.
interface high_score_ram_controller_if;
    import high_score_ram_controller_pkg::*;

    logic               gameOver;
    logic [USER_W-1:0]  userID;
    logic [SCORE_W-1:0] currentGameScore;
    logic               clearScores;
    logic [SCORE_W-1:0] ram_q;
    logic [USER_W-1:0]  ram_addr;
    logic [SCORE_W-1:0] ram_data;
    logic               ram_wren;

    // Game logic and RAM side.
    modport master (
        output gameOver, userID, currentGameScore, clearScores, ram_q,
        input  ram_addr, ram_data, ram_wren
    );

    // Controller side.
    modport slave (
        input  gameOver, userID, currentGameScore, clearScores, ram_q,
        output ram_addr, ram_data, ram_wren
    );

endinterface

// File: rtl/high_score_ram_controller.sv
// Loads per-user high scores from RAM into shadow registers, writes back new
// high scores at game end, and supports a clear-all command.
module high_score_ram_controller
    import high_score_ram_controller_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned NUM_USERS  = DEF_NUM_USERS
) (
    input  logic                       clk,
    input  logic                       rst,
    high_score_ram_controller_if.slave bus,
    output logic [SCORE_W-1:0]         scoreUserAddr0,
    output logic [SCORE_W-1:0]         scoreUserAddr1,
    output logic [SCORE_W-1:0]         scoreUserAddr2,
    output logic [SCORE_W-1:0]         scoreUserAddr3,
    output logic [SCORE_W-1:0]         scoreUserAddr4,
    output logic [SCORE_W-1:0]         scoreUserAddr5,
    output logic                       busy,
    output logic                       newHighScore
);

    localparam logic [USER_W-1:0] LAST_IDX = USER_W'(NUM_USERS - 1);

    state_t             state_q, state_d;
    logic [USER_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    game_req_t          pend_q, pend_d;
    logic               pend_vld_q, pend_vld_d;
    logic [USER_W-1:0]  addr_q, addr_d;
    logic [SCORE_W-1:0] data_q, data_d;
    logic               wren_q, wren_d;
    logic               nhs_d;
    logic               busy_d;
    logic [SCORE_W-1:0] shadow_q [SLOTS];
    logic [SCORE_W-1:0] shadow_d [SLOTS];

    game_req_t          req;
    logic               req_vld;
    game_req_t          live_req;

    assign live_req = '{user: bus.userID, score: bus.currentGameScore};

    // Next state, next registered outputs and next shadow contents.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wren_d     = 1'b0;
        nhs_d      = 1'b0;
        shadow_d   = shadow_q;
        req        = '0;
        req_vld    = 1'b0;

        case (state_q)
            S_LOAD_REQ: begin
                state_d = S_LOAD_WAIT;
                cnt_d   = CNT_W'(RD_LATENCY);
            end
            S_LOAD_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    shadow_d[idx_q] = bus.ram_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + USER_W'(1);
                        addr_d  = idx_d;
                        state_d = S_LOAD_REQ;
                    end
                end
            end
            S_IDLE: begin
                if (bus.clearScores) begin
                    state_d = S_CLEAR;
                    idx_d   = '0;
                end else begin
                    // A live report is newer than anything pending, so it wins.
                    if (bus.gameOver) begin
                        req_vld    = 1'b1;
                        req        = live_req;
                        pend_vld_d = 1'b0;
                    end else if (pend_vld_q) begin
                        req_vld    = 1'b1;
                        req        = pend_q;
                        pend_vld_d = 1'b0;
                    end
                    if (req_vld && (32'(req.user) < NUM_USERS) &&
                        score_gt(req.score, shadow_q[req.user])) begin
                        wren_d                = 1'b1;
                        nhs_d                 = 1'b1;
                        addr_d                = req.user;
                        data_d                = req.score;
                        shadow_d[req.user]    = req.score;
                    end
                end
            end
            S_CLEAR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + USER_W'(1);
                end
            end
            default: begin
                state_d = S_LOAD_REQ;
                idx_d   = '0;
                addr_d  = '0;
            end
        endcase

        // Clear abandons an in-progress load immediately.
        if (((state_q == S_LOAD_REQ) || (state_q == S_LOAD_WAIT)) && bus.clearScores) begin
            state_d = S_CLEAR;
            idx_d   = '0;
        end

        // Game ends seen while busy are held one-deep, last one wins.
        if ((state_q != S_IDLE) && bus.gameOver) begin
            pend_vld_d = 1'b1;
            pend_d     = live_req;
        end

        // Clear writes are aligned with the clear state they belong to.
        if (state_d == S_CLEAR) begin
            wren_d          = 1'b1;
            addr_d          = idx_d;
            data_d          = BLANK_SCORE;
            shadow_d[idx_d] = BLANK_SCORE;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, shadow and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_LOAD_REQ;
            idx_q        <= '0;
            cnt_q        <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            addr_q       <= '0;
            data_q       <= BLANK_SCORE;
            wren_q       <= 1'b0;
            newHighScore <= 1'b0;
            busy         <= 1'b1;
            for (int i = 0; i < int'(SLOTS); i++) begin
                shadow_q[i] <= BLANK_SCORE;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wren_q       <= wren_d;
            newHighScore <= nhs_d;
            busy         <= busy_d;
            shadow_q     <= shadow_d;
        end
    end

    assign bus.ram_addr = addr_q;
    assign bus.ram_data = data_q;
    assign bus.ram_wren = wren_q;

    assign scoreUserAddr0 = shadow_q[0];
    assign scoreUserAddr1 = shadow_q[1];
    assign scoreUserAddr2 = shadow_q[2];
    assign scoreUserAddr3 = shadow_q[3];
    assign scoreUserAddr4 = shadow_q[4];
    assign scoreUserAddr5 = shadow_q[5];

endmodule

// File: tb/tb_high_score_ram_controller.sv
// Self-checking bench: RAM model with 2-cycle read latency plus a
// transaction-level model of the stored high scores.
module tb_high_score_ram_controller;
    import high_score_ram_controller_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    high_score_ram_controller_if bus();
    logic [7:0] so [6];
    logic       busy;
    logic       nhs;

    high_score_ram_controller #(.RD_LATENCY(2), .NUM_USERS(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .scoreUserAddr0 (so[0]),
        .scoreUserAddr1 (so[1]),
        .scoreUserAddr2 (so[2]),
        .scoreUserAddr3 (so[3]),
        .scoreUserAddr4 (so[4]),
        .scoreUserAddr5 (so[5]),
        .busy           (busy),
        .newHighScore   (nhs)
    );

    // Score RAM: synchronous write, two-stage registered read.
    logic [7:0]  mem [8];
    logic [7:0]  img [8];
    logic        load_img = 1'b0;
    logic [7:0]  pipe0, pipe1;
    int unsigned addr_viol = 0;

    always @(posedge clk) begin
        if (load_img) begin
            for (int i = 0; i < 8; i++) mem[i] <= img[i];
        end else if (bus.ram_wren) begin
            mem[bus.ram_addr] <= bus.ram_data;
        end
        pipe0 <= mem[bus.ram_addr];
        pipe1 <= pipe0;
        if (rst && (bus.ram_addr > 3'd5)) addr_viol <= addr_viol + 1;
    end
    assign bus.ram_q = pipe1;

    // Reference model state.
    logic [7:0] exp_sh [8];
    bit         pw;
    logic [2:0] pu;
    logic [7:0] ps;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd_rand();
        logic [3:0] hi, lo;
        hi = 4'($urandom_range(0, 9));
        lo = 4'($urandom_range(0, 9));
        return {hi, lo};
    endfunction

    task automatic check_shadows(input string tag);
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("%s score%0d", tag, i), 32'(so[i]), 32'(exp_sh[i]));
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("%s mem%0d", tag, i), 32'(mem[i]), 32'(exp_sh[i]));
    endtask

    // Reset, optionally reload the RAM image, then time the load. exp_sh must
    // already hold the values the load is expected to bring in.
    task automatic reset_and_load(input bit use_img, input int inj,
                                  input logic [2:0] iu, input logic [7:0] is);
        int n;
        int wr;
        @(negedge clk);
        rst      = 1'b0;
        load_img = use_img;
        @(negedge clk);
        load_img = 1'b0;
        check_eq("rst busy", 32'(busy), 32'd1);
        check_eq("rst wren", 32'(bus.ram_wren), 32'd0);
        check_eq("rst newhs", 32'(nhs), 32'd0);
        check_eq("rst addr", 32'(bus.ram_addr), 32'd0);
        check_eq("rst data", 32'(bus.ram_data), 32'd0);
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("rst score%0d", i), 32'(so[i]), 32'd0);
        rst = 1'b1;
        n  = 0;
        wr = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (bus.ram_wren) wr++;
            bus.gameOver         = (n == inj);
            bus.userID           = iu;
            bus.currentGameScore = is;
        end while (busy && n < 200);
        bus.gameOver = 1'b0;
        check_eq("load cycles", 32'(n), 32'd18);
        check_eq("load wren", 32'(wr), 32'd0);
        check_shadows("load");
    endtask

    // One idle cycle: check the outcome of the previous report, issue a new one.
    task automatic step(input bit go, input logic [2:0] u, input logic [7:0] s);
        @(negedge clk);
        check_eq("wren", 32'(bus.ram_wren), 32'(pw));
        check_eq("newhs", 32'(nhs), 32'(pw));
        if (pw) begin
            check_eq("wr addr", 32'(bus.ram_addr), 32'(pu));
            check_eq("wr data", 32'(bus.ram_data), 32'(ps));
        end
        bus.gameOver         = go;
        bus.userID           = u;
        bus.currentGameScore = s;
        pw = go && (u < 3'd6) && (s > exp_sh[u]);
        if (pw) exp_sh[u] = s;
        pu = u;
        ps = s;
    endtask

    initial begin
        int  n;
        bit  found;
        bus.gameOver         = 1'b0;
        bus.userID           = '0;
        bus.currentGameScore = '0;
        bus.clearScores      = 1'b0;
        pw = 1'b0;
        pu = '0;
        ps = '0;
        img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h05;
        img[3] = 8'h99; img[4] = 8'h00; img[5] = 8'h47;
        img[6] = 8'h00; img[7] = 8'h00;
        for (int i = 0; i < 8; i++) exp_sh[i] = img[i];

        // Power-up load.
        reset_and_load(1'b1, 0, 3'd0, 8'h00);

        // Directed: new high, equal score, out-of-range user.
        step(1'b1, 3'd2, 8'h20);
        step(1'b0, 3'd0, 8'h00);
        step(1'b1, 3'd3, 8'h99);
        step(1'b1, 3'd6, 8'h50);
        step(1'b0, 3'd0, 8'h00);
        check_shadows("directed");

        // Random back-to-back reports.
        for (int i = 0; i < 80; i++)
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), bcd_rand());
        step(1'b0, 3'd0, 8'h00);
        step(1'b0, 3'd0, 8'h00);
        check_shadows("random");
        check_mem("random");

        // Clear with a simultaneous game end; the game end is dropped.
        @(negedge clk);
        bus.clearScores      = 1'b1;
        bus.gameOver         = 1'b1;
        bus.userID           = 3'd0;
        bus.currentGameScore = 8'h80;
        @(negedge clk);
        bus.clearScores = 1'b0;
        bus.gameOver    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("clr%0d wren", i), 32'(bus.ram_wren), 32'd1);
            check_eq($sformatf("clr%0d addr", i), 32'(bus.ram_addr), 32'(i));
            check_eq($sformatf("clr%0d data", i), 32'(bus.ram_data), 32'd0);
            check_eq($sformatf("clr%0d busy", i), 32'(busy), 32'd1);
            @(negedge clk);
        end
        check_eq("clr end wren", 32'(bus.ram_wren), 32'd0);
        check_eq("clr end busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("clr dropped wren", 32'(bus.ram_wren), 32'd0);
        for (int i = 0; i < 8; i++) exp_sh[i] = 8'h00;
        check_shadows("clear");
        check_mem("clear");

        // Game end during load is serviced once the load finishes.
        for (int i = 0; i < 8; i++) exp_sh[i] = img[i];
        reset_and_load(1'b1, 7, 3'd4, 8'h10);
        check_eq("pend first idle wren", 32'(bus.ram_wren), 32'd0);
        @(posedge clk);
        #1;
        check_eq("pend wren", 32'(bus.ram_wren), 32'd1);
        check_eq("pend addr", 32'(bus.ram_addr), 32'd4);
        check_eq("pend data", 32'(bus.ram_data), 32'h10);
        check_eq("pend newhs", 32'(nhs), 32'd1);
        exp_sh[4] = 8'h10;
        @(posedge clk);
        #1;
        check_eq("pend once", 32'(bus.ram_wren), 32'd0);
        check_shadows("pending");

        // Reset in the middle of a clear, then reload what was written so far.
        for (int i = 0; i < 8; i++) exp_sh[i] = img[i];
        reset_and_load(1'b1, 0, 3'd0, 8'h00);
        @(negedge clk);
        bus.clearScores = 1'b1;
        @(negedge clk);
        bus.clearScores = 1'b0;
        n = 0;
        found = 1'b0;
        while (!found && n < 20) begin
            if (bus.ram_wren && bus.ram_addr == 3'd3) found = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check_eq("clr reach idx3", 32'(found), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("abort wren", 32'(bus.ram_wren), 32'd0);
        check_eq("abort busy", 32'(busy), 32'd1);
        check_eq("abort addr", 32'(bus.ram_addr), 32'd0);
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("abort score%0d", i), 32'(so[i]), 32'd0);
        exp_sh[0] = 8'h00;
        exp_sh[1] = 8'h00;
        exp_sh[2] = 8'h00;
        reset_and_load(1'b0, 0, 3'd0, 8'h00);
        check_mem("abort");

        check_eq("addr range", 32'(addr_viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
